// File: rtl/amo_manager_pkg.sv
// Shared AMO types for the load/store path: amo_t function codes,
// reservation FSM states and the core-level reservation timeout default.
package amo_manager_pkg;

  localparam int RESERVATION_TIMEOUT_DEFAULT = 64;

  // RISC-V funct5 encodings of the A extension
  typedef enum logic [4:0] {
    AMO_ADD_FN5  = 5'b00000,
    AMO_SWAP_FN5 = 5'b00001,
    AMO_LR_FN5   = 5'b00010,
    AMO_SC_FN5   = 5'b00011,
    AMO_XOR_FN5  = 5'b00100,
    AMO_OR_FN5   = 5'b01000,
    AMO_AND_FN5  = 5'b01100,
    AMO_MIN_FN5  = 5'b10000,
    AMO_MAX_FN5  = 5'b10100,
    AMO_MINU_FN5 = 5'b11000,
    AMO_MAXU_FN5 = 5'b11100
  } amo_t;

  typedef enum logic {
    RES_IDLE     = 1'b0,
    RES_RESERVED = 1'b1
  } res_state_t;

  function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/amo_if.sv
// Bundle between AMO-capable sub-units (master) and the amo_manager (slave).
interface amo_if #(
  parameter int NUM_PORTS = 2
);

  // There is no backpressure: every per-port qualifier (set_reservation,
  // clear_reservation, rmw_valid) is a single-cycle strobe that the manager
  // always accepts, and reservation_valid/rd answer combinationally in that
  // same cycle.
  logic [NUM_PORTS-1:0]       set_reservation;
  logic [NUM_PORTS-1:0]       clear_reservation;
  logic [NUM_PORTS-1:0][31:0] reservation;
  logic [NUM_PORTS-1:0]       reservation_valid;
  logic [NUM_PORTS-1:0]       rmw_valid;
  logic [NUM_PORTS-1:0][4:0]  op;
  logic [NUM_PORTS-1:0][31:0] rs1;
  logic [NUM_PORTS-1:0][31:0] rs2;
  logic [31:0]                rd;

  modport master (
    output set_reservation, clear_reservation, reservation,
    output rmw_valid, op, rs1, rs2,
    input  reservation_valid, rd
  );

  modport slave (
    input  set_reservation, clear_reservation, reservation,
    input  rmw_valid, op, rs1, rs2,
    output reservation_valid, rd
  );

endinterface

// File: rtl/amo_manager_alu.sv
// Combinational AMO read-modify-write ALU; usable by any AMO source.
module amo_manager_alu
  import amo_manager_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] rd
);

  always_comb begin
    rd = rs1;
    case (op)
      AMO_ADD_FN5:  rd = rs1 + rs2;
      AMO_SWAP_FN5: rd = rs2;
      AMO_XOR_FN5:  rd = rs1 ^ rs2;
      AMO_OR_FN5:   rd = rs1 | rs2;
      AMO_AND_FN5:  rd = rs1 & rs2;
      AMO_MIN_FN5:  rd = ($signed(rs1) < $signed(rs2)) ? rs1 : rs2;
      AMO_MAX_FN5:  rd = ($signed(rs1) < $signed(rs2)) ? rs2 : rs1;
      AMO_MINU_FN5: rd = (rs1 < rs2) ? rs1 : rs2;
      AMO_MAXU_FN5: rd = (rs1 < rs2) ? rs2 : rs1;
      // LR, SC and unused codes write the memory value back unchanged
      default:      rd = rs1;
    endcase
  end

endmodule

// File: rtl/amo_manager.sv
// Hart-wide LR/SC reservation tracker and shared AMO RMW ALU for all
// AMO-capable memory sub-units.
module amo_manager
  import amo_manager_pkg::*;
#(
  parameter int NUM_PORTS           = 2,
  parameter int RESERVATION_TIMEOUT = RESERVATION_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  amo_if.slave        amo,
  input  logic        snoop_valid,
  input  logic [29:0] snoop_addr,
  output logic        rmw_conflict,
  output res_state_t  state_dbg
);

  localparam int TW = (RESERVATION_TIMEOUT > 0) ? $clog2(RESERVATION_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST =
    (RESERVATION_TIMEOUT > 0) ? TW'(RESERVATION_TIMEOUT - 1) : '0;

  res_state_t  state;
  logic [29:0] res_addr;
  logic [TW-1:0] res_timer;
  logic        res_valid;

  logic        any_set;
  logic        any_clear;
  logic [29:0] set_addr;
  logic        snoop_hit;
  logic        timeout_hit;

  assign res_valid   = (state == RES_RESERVED);
  assign any_set     = |amo.set_reservation;
  assign any_clear   = |amo.clear_reservation;
  assign snoop_hit   = snoop_valid && res_valid && (snoop_addr == res_addr);
  assign timeout_hit = (RESERVATION_TIMEOUT != 0) && (res_timer == TIMER_LAST);
  assign state_dbg   = state;

  // Lowest-indexed setting port wins: scan downward so port 0 is applied last
  always_comb begin
    set_addr = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (amo.set_reservation[i]) set_addr = word_addr(amo.reservation[i]);
    end
  end

  // Answered from the pre-edge state so an SC checks before its own clear lands
  always_comb begin
    amo.reservation_valid = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      amo.reservation_valid[i] = res_valid && (word_addr(amo.reservation[i]) == res_addr);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RES_IDLE;
      res_addr  <= '0;
      res_timer <= '0;
    end else if (any_set) begin
      // An LR raises both set and clear; set takes priority over every clear source
      state     <= RES_RESERVED;
      res_addr  <= set_addr;
      res_timer <= '0;
    end else begin
      case (state)
        RES_IDLE: begin
          res_timer <= '0;
        end
        RES_RESERVED: begin
          if (any_clear || snoop_hit || timeout_hit) begin
            state     <= RES_IDLE;
            res_timer <= '0;
          end else if (RESERVATION_TIMEOUT != 0) begin
            res_timer <= res_timer + 1'b1;
          end
        end
        default: begin
          state     <= RES_IDLE;
          res_timer <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rmw_conflict <= 1'b0;
    end else if ($countones(amo.rmw_valid) > 1) begin
      rmw_conflict <= 1'b1;
    end
  end

  logic [4:0]  alu_op;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;

  // Port 0 drives the ALU by default so rd is defined when no port is active
  always_comb begin
    alu_op  = amo.op[0];
    alu_rs1 = amo.rs1[0];
    alu_rs2 = amo.rs2[0];
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (amo.rmw_valid[i]) begin
        alu_op  = amo.op[i];
        alu_rs1 = amo.rs1[i];
        alu_rs2 = amo.rs2[i];
      end
    end
  end

  amo_manager_alu u_alu (
    .op  (alu_op),
    .rs1 (alu_rs1),
    .rs2 (alu_rs2),
    .rd  (amo.rd)
  );

endmodule

// File: tb/tb_amo_manager.sv
// Directed bench for amo_manager: reservation lifecycle, snoop, timeout,
// ALU vector table, conflict flag and asynchronous reset.
module tb_amo_manager;
  import amo_manager_pkg::*;

  logic clk;
  logic rst;
  logic snoop_valid;
  logic [29:0] snoop_addr;
  logic rmw_conflict;
  logic rmw_conflict0;
  res_state_t state_dbg;
  res_state_t state_dbg0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  amo_if #(.NUM_PORTS(2)) bus ();
  amo_if #(.NUM_PORTS(2)) bus0 ();

  amo_manager #(.NUM_PORTS(2), .RESERVATION_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .amo          (bus),
    .snoop_valid  (snoop_valid),
    .snoop_addr   (snoop_addr),
    .rmw_conflict (rmw_conflict),
    .state_dbg    (state_dbg)
  );

  amo_manager #(.NUM_PORTS(2), .RESERVATION_TIMEOUT(0)) dut0 (
    .clk          (clk),
    .rst          (rst),
    .amo          (bus0),
    .snoop_valid  (1'b0),
    .snoop_addr   (30'd0),
    .rmw_conflict (rmw_conflict0),
    .state_dbg    (state_dbg0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // drivers
  task automatic idle();
    bus.set_reservation    = '0;
    bus.clear_reservation  = '0;
    bus.rmw_valid          = '0;
    bus0.set_reservation   = '0;
    bus0.clear_reservation = '0;
    bus0.rmw_valid         = '0;
    snoop_valid            = 1'b0;
  endtask

  task automatic drive_req(input int p, input logic set, input logic clr, input logic [31:0] addr);
    bus.set_reservation[p]   = set;
    bus.clear_reservation[p] = clr;
    bus.reservation[p]       = addr;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  rmw;
    logic [4:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{"add",   2'b10, AMO_ADD_FN5,  32'hFFFFFFFE, 32'h3, 32'h00000001};
    vecs[1]  = '{"swap",  2'b10, AMO_SWAP_FN5, 32'hFFFFFFFE, 32'h3, 32'h00000003};
    vecs[2]  = '{"xor",   2'b10, AMO_XOR_FN5,  32'hFFFFFFFE, 32'h3, 32'hFFFFFFFD};
    vecs[3]  = '{"and",   2'b10, AMO_AND_FN5,  32'hFFFFFFFE, 32'h3, 32'h00000002};
    vecs[4]  = '{"or",    2'b10, AMO_OR_FN5,   32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF};
    vecs[5]  = '{"min",   2'b10, AMO_MIN_FN5,  32'hFFFFFFFE, 32'h3, 32'hFFFFFFFE};
    vecs[6]  = '{"max",   2'b10, AMO_MAX_FN5,  32'hFFFFFFFE, 32'h3, 32'h00000003};
    vecs[7]  = '{"minu",  2'b10, AMO_MINU_FN5, 32'hFFFFFFFE, 32'h3, 32'h00000003};
    vecs[8]  = '{"maxu",  2'b10, AMO_MAXU_FN5, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFE};
    vecs[9]  = '{"lr",    2'b10, AMO_LR_FN5,   32'hFFFFFFFE, 32'h3, 32'hFFFFFFFE};
    vecs[10] = '{"sc",    2'b10, AMO_SC_FN5,   32'hFFFFFFFE, 32'h3, 32'hFFFFFFFE};
    vecs[11] = '{"undef", 2'b10, 5'b00101,     32'hFFFFFFFE, 32'h3, 32'hFFFFFFFE};
    // no port active: port 0 operands (ADD 0x11111111 + 0x22222222)
    vecs[12] = '{"none",  2'b00, AMO_XOR_FN5,  32'hFFFFFFFE, 32'h3, 32'h33333333};

    rst = 1'b0;
    snoop_addr = '0;
    bus.reservation  = '0;
    bus0.reservation = '0;
    bus.op  = '0;
    bus.rs1 = '0;
    bus.rs2 = '0;
    bus0.op  = '0;
    bus0.rs1 = '0;
    bus0.rs2 = '0;
    idle();
    bus.op[0]  = AMO_ADD_FN5;
    bus.rs1[0] = 32'd5;
    bus.rs2[0] = 32'd7;
    bus.op[1]  = AMO_SWAP_FN5;
    bus.rs1[1] = 32'hAAAA0000;
    bus.rs2[1] = 32'h0000BBBB;
    repeat (3) @(negedge clk);
    #1;
    check("reset_rv", 32'(bus.reservation_valid), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    check("reset_conflict", 32'(rmw_conflict), 32'd0);
    check("reset_rd_port0", bus.rd, 32'd12);
    @(negedge clk);
    rst = 1'b1;

    // LR then SC to the same word, then a second SC
    @(negedge clk); idle(); drive_req(0, 1, 1, 32'h1000);
    #1 check("lr_pre_valid", 32'(bus.reservation_valid[0]), 32'd0);
    @(negedge clk); idle(); drive_req(0, 0, 1, 32'h1000);
    #1 check("sc_sees_valid", 32'(bus.reservation_valid[0]), 32'd1);
    check("sc_state_reserved", 32'(state_dbg), 32'd1);
    @(negedge clk); idle(); drive_req(0, 0, 1, 32'h1000);
    #1 check("sc2_sees_clear", 32'(bus.reservation_valid[0]), 32'd0);
    check("sc2_state_idle", 32'(state_dbg), 32'd0);

    // SC to a different word
    @(negedge clk); idle(); drive_req(0, 1, 1, 32'h1000);
    @(negedge clk); idle(); drive_req(0, 0, 1, 32'h1004);
    #1 check("sc_mismatch", 32'(bus.reservation_valid[0]), 32'd0);
    @(negedge clk); idle(); bus.reservation[0] = 32'h1000;
    #1 check("mismatch_cleared", 32'(bus.reservation_valid[0]), 32'd0);

    // Snoop hit drops the reservation; a neighbouring word does not
    @(negedge clk); idle(); drive_req(0, 1, 1, 32'h2000);
    @(negedge clk); idle(); snoop_valid = 1'b1; snoop_addr = 30'h800;
    bus.reservation[1] = 32'h2003;
    #1 check("snoop_pre_port1", 32'(bus.reservation_valid), 32'd3);
    @(negedge clk); idle();
    #1 check("snoop_hit_drop", 32'(bus.reservation_valid[0]), 32'd0);
    @(negedge clk); idle(); drive_req(0, 1, 1, 32'h2000);
    @(negedge clk); idle(); snoop_valid = 1'b1; snoop_addr = 30'h801;
    @(negedge clk); idle();
    #1 check("snoop_miss_keep", 32'(bus.reservation_valid[0]), 32'd1);
    @(negedge clk); idle(); drive_req(0, 0, 1, 32'h2000);
    @(negedge clk); idle();
    #1 check("clear_after_snoop", 32'(state_dbg), 32'd0);

    // Timeout of 4: valid for exactly four cycles after the set edge
    @(negedge clk); idle(); drive_req(0, 1, 1, 32'h3000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); idle();
      #1 check($sformatf("timeout_live_%0d", k), 32'(bus.reservation_valid[0]), 32'd1);
    end
    @(negedge clk); idle();
    #1 check("timeout_expired", 32'(bus.reservation_valid[0]), 32'd0);

    // Two ports set together: port 0 wins
    @(negedge clk); idle(); drive_req(0, 1, 1, 32'h5000); drive_req(1, 1, 1, 32'h6000);
    @(negedge clk); idle();
    #1 check("dual_set_port0", 32'(bus.reservation_valid), 32'd1);
    // Set beats a simultaneous clear and snoop hit
    @(negedge clk); idle(); drive_req(1, 1, 1, 32'h6000); drive_req(0, 0, 1, 32'h5000);
    snoop_valid = 1'b1; snoop_addr = 30'h1400;
    @(negedge clk); idle();
    #1 check("set_priority", 32'(bus.reservation_valid), 32'd2);
    @(negedge clk); idle(); drive_req(1, 0, 1, 32'h6000);
    @(negedge clk); idle();

    // Timeout disabled: reservation survives 1000 idle cycles
    @(negedge clk); idle();
    bus0.set_reservation[0] = 1'b1; bus0.clear_reservation[0] = 1'b1;
    bus0.reservation[0] = 32'h7000;
    @(negedge clk); idle();
    repeat (1000) @(negedge clk);
    #1 check("no_timeout_valid", 32'(bus0.reservation_valid[0]), 32'd1);
    check("no_timeout_state", 32'(state_dbg0), 32'd1);

    // ALU vector table: port 1 operands, port 0 fixed at ADD 0x11111111+0x22222222
    bus.op[0]  = AMO_ADD_FN5;
    bus.rs1[0] = 32'h11111111;
    bus.rs2[0] = 32'h22222222;
    foreach (vecs[i]) begin
      @(negedge clk); idle();
      bus.rmw_valid = vecs[i].rmw;
      bus.op[1]     = vecs[i].op;
      bus.rs1[1]    = vecs[i].rs1;
      bus.rs2[1]    = vecs[i].rs2;
      exp_q.push_back(vecs[i].exp);
      #1 check({"alu_", vecs[i].name}, bus.rd, exp_q.pop_front());
    end
    @(negedge clk); idle();
    #1 check("no_conflict_single", 32'(rmw_conflict), 32'd0);

    // Two ports in one cycle: port 0 drives rd, conflict sticks
    @(negedge clk); idle(); bus.rmw_valid = 2'b11;
    #1 check("conflict_rd_port0", bus.rd, 32'h33333333);
    @(negedge clk); idle();
    #1 check("conflict_set", 32'(rmw_conflict), 32'd1);
    repeat (3) @(negedge clk);
    #1 check("conflict_held", 32'(rmw_conflict), 32'd1);

    // Asynchronous reset mid-reservation
    @(negedge clk); idle(); drive_req(0, 1, 1, 32'h1000);
    @(negedge clk); idle();
    #1 check("pre_reset_valid", 32'(bus.reservation_valid[0]), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("async_rst_rv", 32'(bus.reservation_valid), 32'd0);
    check("async_rst_state", 32'(state_dbg), 32'd0);
    check("async_rst_conflict", 32'(rmw_conflict), 32'd0);
    check("async_rst_rd", bus.rd, 32'h33333333);
    check("async_rst_dut0", 32'(bus0.reservation_valid[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
